// File: rtl/read_command_credit_arbiter.sv
// Round-robin arbiter sharing one memory read-command channel between NUM_REQ requesters,
// with per-requester outstanding-response credits and a run/drain control FSM.
module read_command_credit_arbiter #(
  parameter int NUM_REQ         = 2,
  parameter int DATA_WIDTH      = 64,
  parameter int MAX_OUTSTANDING = 16,
  parameter int CNT_WIDTH       = 5,
  parameter int STRUCT_WIDTH    = 4,
  parameter logic [STRUCT_WIDTH-1:0] STRUCT_INVALID = '1,
  localparam int ID_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           clock,
  input  logic                           rstn,
  input  logic                           enable,
  input  logic                           drain_req,
  input  logic [0:NUM_REQ-1]             req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_cmd,
  input  logic [NUM_REQ*STRUCT_WIDTH-1:0] req_struct,
  output logic [0:NUM_REQ-1]             req_ready,
  output logic [DATA_WIDTH-1:0]          cmd_out,
  output logic [STRUCT_WIDTH-1:0]        cmd_out_struct,
  output logic                           cmd_out_valid,
  input  logic                           cmd_out_ready,
  input  logic                           rsp_valid,
  input  logic [ID_WIDTH-1:0]            rsp_id,
  output logic                           drain_done,
  output logic                           credit_error
);

  localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_OUTSTANDING);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DRAINED} state_t;

  state_t                    state;
  state_t                    state_next;
  logic [ID_WIDTH-1:0]       rr_ptr;
  logic [CNT_WIDTH-1:0]      outstanding [NUM_REQ];

  logic [0:NUM_REQ-1]        eligible;
  logic [0:NUM_REQ-1]        rsp_hit;
  logic [0:NUM_REQ-1]        cnt_zero;
  logic [0:NUM_REQ-1]        underflow;
  logic [0:NUM_REQ-1]        grant;
  logic                      grant_any;
  logic [ID_WIDTH-1:0]       grant_idx;
  logic                      out_free;
  logic                      quiet;
  logic [DATA_WIDTH-1:0]     sel_cmd_p0;
  logic [STRUCT_WIDTH-1:0]   sel_struct_p0;

  // Index arithmetic modulo NUM_REQ for the round-robin search and pointer advance.
  function automatic logic [ID_WIDTH-1:0] wrap_add(input logic [ID_WIDTH-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return ID_WIDTH'(sum);
  endfunction

  // Credit counter step: simultaneous grant and response cancel; floor at zero.
  function automatic logic [CNT_WIDTH-1:0] step_count(input logic [CNT_WIDTH-1:0] cnt,
                                                       input logic inc, input logic dec);
    logic [CNT_WIDTH-1:0] nxt;
    nxt = cnt;
    if (inc && !dec) nxt = cnt + CNT_ONE;
    else if (dec && !inc && cnt != '0) nxt = cnt - CNT_ONE;
    return nxt;
  endfunction

  always_comb begin
    eligible  = '0;
    rsp_hit   = '0;
    cnt_zero  = '0;
    underflow = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i]  = req_valid[i] && (outstanding[i] < MAX_CNT);
      rsp_hit[i]   = rsp_valid && (rsp_id == ID_WIDTH'(i));
      cnt_zero[i]  = (outstanding[i] == '0);
      underflow[i] = rsp_hit[i] && !grant[i] && cnt_zero[i];
    end
  end

  assign out_free = !cmd_out_valid || cmd_out_ready;
  assign quiet    = !cmd_out_valid && (&cnt_zero);

  // Round-robin search from the pointer; independent of the command payload.
  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    if (state == RUN && out_free) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!grant_any && eligible[wrap_add(rr_ptr, k)]) begin
          grant_any = 1'b1;
          grant_idx = wrap_add(rr_ptr, k);
        end
      end
      if (grant_any) grant[grant_idx] = 1'b1;
    end
  end

  assign req_ready = grant;

  always_comb begin
    sel_cmd_p0    = '0;
    sel_struct_p0 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_cmd_p0    = req_cmd[i*DATA_WIDTH +: DATA_WIDTH];
        sel_struct_p0 = req_struct[i*STRUCT_WIDTH +: STRUCT_WIDTH];
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable) state_next = RUN;
      RUN: begin
        if (drain_req)    state_next = DRAIN;
        else if (!enable) state_next = IDLE;
      end
      DRAIN:   if (quiet) state_next = DRAINED;
      DRAINED: if (!enable) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      drain_done <= 1'b0;
      rr_ptr     <= '0;
    end else begin
      state      <= state_next;
      drain_done <= (state_next == DRAINED);
      if (grant_any) rr_ptr <= wrap_add(grant_idx, 1);
    end
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_REQ; i++) outstanding[i] <= '0;
      credit_error <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++)
        outstanding[i] <= step_count(outstanding[i], grant[i], rsp_hit[i]);
      if (|underflow) credit_error <= 1'b1;
    end
  end

  // p0 -> output register: one-cycle grant-to-command latency, holds while stalled.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      cmd_out        <= '0;
      cmd_out_struct <= STRUCT_INVALID;
      cmd_out_valid  <= 1'b0;
    end else if (grant_any) begin
      cmd_out        <= sel_cmd_p0;
      cmd_out_struct <= sel_struct_p0;
      cmd_out_valid  <= 1'b1;
    end else if (cmd_out_ready) begin
      cmd_out_valid  <= 1'b0;
    end
  end

endmodule
